// File: rtl/pmod_16led_pattern_if.sv
// Control and LED bus of the 16-LED PMOD pattern generator.
// The master drives the pattern controls and the slave (the generator)
// returns the step tick and the registered LED drive.
interface pmod_16led_pattern_if #(
    parameter int N_LED = 16
) ();
    logic [1:0]       mode;
    logic             run;
    logic             step;
    logic             dir;
    logic             tick;
    logic [N_LED-1:0] pmod_16led;

    modport master (
        output mode, run, step, dir,
        input  tick, pmod_16led
    );

    modport slave (
        input  mode, run, step, dir,
        output tick, pmod_16led
    );
endinterface

// File: rtl/pmod_16led_pattern.sv
// LED pattern generator for the 16-LED PMOD.
// A free-running divider produces a step tick; each advance moves one of
// four patterns (binary, Gray, bouncing scanner, bar graph) on the lower
// LEDs. With HB_EN set, the MSB is a heartbeat that toggles on every tick.
module pmod_16led_pattern #(
    parameter int N_LED = 16,
    parameter int DIV   = 12500000,
    parameter int HB_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmod_16led_pattern_if.slave   bus
);
    // Pattern width: the heartbeat, when present, takes the MSB.
    localparam int W  = (HB_EN != 0) ? N_LED - 1 : N_LED;
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PW = $clog2(W);
    localparam int LW = $clog2(W + 1);

    localparam logic [N_LED-1:0] LED_RST = (HB_EN != 0) ?
        {1'b1, {(N_LED-1){1'b0}}} : {N_LED{1'b0}};

    logic [DW-1:0]    div_cnt_r;
    logic             tick_r;
    logic             step_q_r;
    logic [1:0]       mode_q_r;
    logic [W-1:0]     cnt_r;
    logic [PW-1:0]    pos_r;
    logic             sdir_r;      // 1 = moving up
    logic [LW-1:0]    lvl_r;
    logic [N_LED-1:0] led_r;

    logic             adv_s;
    logic             mode_chg_s;
    logic [W-1:0]     pat_s;
    logic [N_LED-1:0] led_nxt_s;

    // Free-running divider; tick is registered so it lands the cycle after the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            tick_r <= (div_cnt_r == DW'(DIV - 1));
            if (div_cnt_r == DW'(DIV - 1)) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end
    end

    // Advance on ticks while running, otherwise on a manual step rising edge;
    // a mode change takes priority and swallows a coincident advance.
    always_comb begin
        adv_s      = 1'b0;
        mode_chg_s = (bus.mode != mode_q_r);
        if (bus.run) begin
            adv_s = tick_r;
        end else begin
            adv_s = bus.step & ~step_q_r;
        end
    end

    // Edge-detect and mode-change history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q_r <= 1'b0;
            mode_q_r <= 2'b00;
        end else begin
            step_q_r <= bus.step;
            mode_q_r <= bus.mode;
        end
    end

    // Pattern state: reload on mode change, otherwise step the active pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            pos_r  <= '0;
            sdir_r <= 1'b1;
            lvl_r  <= '0;
        end else if (mode_chg_s) begin
            cnt_r  <= '0;
            pos_r  <= '0;
            sdir_r <= 1'b1;
            lvl_r  <= '0;
        end else if (adv_s) begin
            case (mode_q_r)
                2'b00, 2'b01: begin
                    if (bus.dir) begin
                        cnt_r <= cnt_r + W'(1);
                    end else begin
                        cnt_r <= cnt_r - W'(1);
                    end
                end
                2'b10: begin
                    // Reversal happens on arrival at an end, so each end LED shows for one step.
                    if (sdir_r) begin
                        if (pos_r >= PW'(W - 2)) begin
                            pos_r  <= PW'(W - 1);
                            sdir_r <= 1'b0;
                        end else begin
                            pos_r <= pos_r + PW'(1);
                        end
                    end else begin
                        if (pos_r <= PW'(1)) begin
                            pos_r  <= '0;
                            sdir_r <= 1'b1;
                        end else begin
                            pos_r <= pos_r - PW'(1);
                        end
                    end
                end
                2'b11: begin
                    if (bus.dir) begin
                        if (lvl_r >= LW'(W)) begin
                            lvl_r <= '0;
                        end else begin
                            lvl_r <= lvl_r + LW'(1);
                        end
                    end else begin
                        if ((lvl_r == '0) || (lvl_r > LW'(W))) begin
                            lvl_r <= LW'(W);
                        end else begin
                            lvl_r <= lvl_r - LW'(1);
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Decode the current pattern state into the lower LED bits.
    always_comb begin
        pat_s = '0;
        case (mode_q_r)
            2'b00: pat_s = cnt_r;
            2'b01: pat_s = cnt_r ^ (cnt_r >> 1'b1);
            2'b10: pat_s = W'(1) << pos_r;
            2'b11: begin
                for (int i = 0; i < W; i++) begin
                    pat_s[i] = (i < int'(lvl_r));
                end
            end
            default: pat_s = '0;
        endcase
    end

    if (HB_EN != 0) begin : g_hb
        logic hb_r;

        // Heartbeat toggles on every tick, independent of run.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hb_r <= 1'b1;
            end else if (tick_r) begin
                hb_r <= ~hb_r;
            end
        end

        assign led_nxt_s = {hb_r, pat_s};
    end else begin : g_no_hb
        assign led_nxt_s = pat_s;
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= LED_RST;
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign bus.tick       = tick_r;
    assign bus.pmod_16led = led_r;
endmodule

// File: tb/tb_pmod_16led_pattern.sv
// Self-checking bench for pmod_16led_pattern: a 16-LED heartbeat instance
// and a 5-LED instance without heartbeat, both with DIV=4.
module tb_pmod_16led_pattern;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pmod_16led_pattern_if #(.N_LED(16)) bus_a ();
    pmod_16led_pattern_if #(.N_LED(5))  bus_b ();

    pmod_16led_pattern #(.N_LED(16), .DIV(4), .HB_EN(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pmod_16led_pattern #(.N_LED(5), .DIV(4), .HB_EN(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        bit          sel;    // 0 = 16-LED instance, 1 = 5-LED instance
        logic [1:0]  mode;
        logic        dir;
        logic        step;
        logic [15:0] exp;    // expected pattern bits (heartbeat masked)
    } vec_t;

    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] tick_hist;
    logic [15:0] led_hist [0:14];
    logic        found;
    logic        prev_hb;
    int          toggles;

    task automatic add(input bit sel, input logic [1:0] mode, input logic dir,
                       input logic step, input logic [15:0] exp);
        vec_t v;
        v.sel = sel; v.mode = mode; v.dir = dir; v.step = step; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] low_a();
        return {1'b0, bus_a.pmod_16led[14:0]};
    endfunction

    function automatic logic [15:0] led_b();
        return {11'd0, bus_b.pmod_16led};
    endfunction

    // Wait (bounded) until the 16-LED instance shows a tick.
    task automatic wait_tick();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            if (bus_a.tick) found = 1'b1;
        end
        check("tick_found", {15'd0, found}, 16'h0001);
    endtask

    initial begin
        // 16-LED instance: down count, wrap, Gray, bar, scanner start.
        add(1'b0, 2'b00, 1'b0, 1'b1, 16'h7FFF);
        add(1'b0, 2'b00, 1'b1, 1'b1, 16'h0000);
        add(1'b0, 2'b00, 1'b1, 1'b1, 16'h0001);
        add(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000);
        add(1'b0, 2'b01, 1'b1, 1'b1, 16'h0001);
        add(1'b0, 2'b01, 1'b1, 1'b1, 16'h0003);
        add(1'b0, 2'b01, 1'b1, 1'b1, 16'h0002);
        add(1'b0, 2'b01, 1'b1, 1'b1, 16'h0006);
        add(1'b0, 2'b01, 1'b0, 1'b1, 16'h0002);
        add(1'b0, 2'b11, 1'b1, 1'b0, 16'h0000);
        add(1'b0, 2'b11, 1'b1, 1'b1, 16'h0001);
        add(1'b0, 2'b11, 1'b1, 1'b1, 16'h0003);
        add(1'b0, 2'b11, 1'b0, 1'b1, 16'h0001);
        add(1'b0, 2'b10, 1'b0, 1'b0, 16'h0001);
        add(1'b0, 2'b10, 1'b0, 1'b1, 16'h0002);
        // 5-LED instance: scanner bounce with dir toggling, then bar wrap.
        add(1'b1, 2'b10, 1'b0, 1'b0, 16'h0001);
        add(1'b1, 2'b10, 1'b1, 1'b1, 16'h0002);
        add(1'b1, 2'b10, 1'b0, 1'b1, 16'h0004);
        add(1'b1, 2'b10, 1'b1, 1'b1, 16'h0008);
        add(1'b1, 2'b10, 1'b0, 1'b1, 16'h0010);
        add(1'b1, 2'b10, 1'b1, 1'b1, 16'h0008);
        add(1'b1, 2'b10, 1'b0, 1'b1, 16'h0004);
        add(1'b1, 2'b10, 1'b1, 1'b1, 16'h0002);
        add(1'b1, 2'b10, 1'b0, 1'b1, 16'h0001);
        add(1'b1, 2'b10, 1'b1, 1'b1, 16'h0002);
        add(1'b1, 2'b11, 1'b1, 1'b0, 16'h0000);
        add(1'b1, 2'b11, 1'b1, 1'b1, 16'h0001);
        add(1'b1, 2'b11, 1'b1, 1'b1, 16'h0003);
        add(1'b1, 2'b11, 1'b1, 1'b1, 16'h0007);
        add(1'b1, 2'b11, 1'b1, 1'b1, 16'h000F);
        add(1'b1, 2'b11, 1'b1, 1'b1, 16'h001F);
        add(1'b1, 2'b11, 1'b1, 1'b1, 16'h0000);
        add(1'b1, 2'b11, 1'b0, 1'b1, 16'h001F);
        add(1'b1, 2'b11, 1'b0, 1'b1, 16'h000F);

        bus_a.mode = 2'b00; bus_a.run = 1'b1; bus_a.step = 1'b0; bus_a.dir = 1'b1;
        bus_b.mode = 2'b00; bus_b.run = 1'b0; bus_b.step = 1'b0; bus_b.dir = 1'b0;

        // Reset values.
        rst_n = 1'b0;
        cyc(3);
        check("reset_led_a", bus_a.pmod_16led, 16'h8000);
        check("reset_led_b", led_b(), 16'h0000);
        check("reset_tick", {15'd0, bus_a.tick}, 16'h0000);

        // Divider and free-running binary count with heartbeat.
        rst_n = 1'b1;
        tick_hist = 16'h0000;
        for (int i = 1; i <= 14; i++) begin
            cyc(1);
            tick_hist[i] = bus_a.tick;
            led_hist[i]  = bus_a.pmod_16led;
        end
        check("tick_period", tick_hist, 16'h1110);
        check("led_c5", led_hist[5], 16'h8000);
        check("led_c6", led_hist[6], 16'h0001);
        check("led_c10", led_hist[10], 16'h8002);
        check("led_c14", led_hist[14], 16'h0003);

        // Asynchronous reset mid-sequence, observed before the next edge.
        rst_n = 1'b0;
        #2;
        check("midreset_led", bus_a.pmod_16led, 16'h8000);
        check("midreset_tick", {15'd0, bus_a.tick}, 16'h0000);
        cyc(1);
        bus_a.run = 1'b0;
        rst_n = 1'b1;

        // Table of step-driven vectors.
        foreach (vecs[k]) begin
            if (!vecs[k].sel) begin
                bus_a.mode = vecs[k].mode; bus_a.dir = vecs[k].dir; bus_a.step = vecs[k].step;
            end else begin
                bus_b.mode = vecs[k].mode; bus_b.dir = vecs[k].dir; bus_b.step = vecs[k].step;
            end
            cyc(1);
            bus_a.step = 1'b0;
            bus_b.step = 1'b0;
            cyc(1);
            check($sformatf("vec%0d", k), vecs[k].sel ? led_b() : low_a(), vecs[k].exp);
        end

        // 10-cycle step pulse: one advance, 2 cycles after the rise; heartbeat still runs.
        bus_a.step = 1'b1;
        cyc(1);
        check("step_lat1", low_a(), 16'h0002);
        cyc(1);
        check("step_lat2", low_a(), 16'h0004);
        prev_hb = bus_a.pmod_16led[15];
        toggles = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (bus_a.pmod_16led[15] != prev_hb) toggles++;
            prev_hb = bus_a.pmod_16led[15];
        end
        bus_a.step = 1'b0;
        cyc(2);
        check("step_hold", low_a(), 16'h0004);
        check("hb_toggles_run0", 16'(toggles), 16'h0002);

        // Mode change reloads binary counter to 0.
        bus_a.mode = 2'b00;
        bus_a.dir  = 1'b1;
        cyc(2);
        check("reload_bin", low_a(), 16'h0000);

        // run=1: tick advances, step is ignored.
        wait_tick();
        bus_a.run = 1'b1;
        cyc(1);
        bus_a.step = 1'b1;
        cyc(2);
        check("run_step_ignored", low_a(), 16'h0001);
        bus_a.step = 1'b0;
        cyc(3);
        check("run_next_tick", low_a(), 16'h0002);
        bus_a.run = 1'b0;

        // Collision: mode change and step edge in the same cycle.
        bus_a.mode = 2'b11;
        bus_a.step = 1'b1;
        cyc(1);
        bus_a.step = 1'b0;
        cyc(1);
        check("collide_step", low_a(), 16'h0000);
        bus_a.step = 1'b1;
        cyc(1);
        bus_a.step = 1'b0;
        cyc(1);
        check("after_collide", low_a(), 16'h0001);

        // Collision: mode change and tick-driven advance in the same cycle.
        wait_tick();
        bus_a.run  = 1'b1;
        bus_a.mode = 2'b01;
        cyc(2);
        bus_a.run = 1'b0;
        check("collide_tick", low_a(), 16'h0000);
        cyc(1);
        check("collide_tick_hold", low_a(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pmod_16led_pattern.md
# pmod_16led_pattern

Parametrised LED pattern generator for the 16-LED PMOD, successor to the fixed 1 Hz counter demo. A clock divider produces a step tick; on each step the block advances one of four selectable patterns (binary, Gray, bouncing scanner, bar graph) on the lower LEDs. An optional heartbeat LED on the MSB toggles every tick. It sits directly behind the PMOD pins in the ULX3S top level; the top level still ties `gpio0` high.

## Interface
- `N_LED`, default 16: number of LED outputs; must be at least 3.
- `DIV`, default 12500000: clock cycles per step tick; must be at least 2. The default gives a 2 Hz tick at 25 MHz.
- `HB_EN`, default 1: 1 = MSB is the heartbeat, and the pattern width W = N_LED-1; 0 = no heartbeat, and W = N_LED.

- `clk` input 1: system clock, 25 MHz on ULX3S.
- `rst_n` input 1: asynchronous, active-low reset.
- `mode` input 2: pattern select.
  - 00 binary
  - 01 Gray
  - 10 scanner
  - 11 bar
- `run` input 1: 1 = advance on every tick; 0 = advance only on `step` rising edges.
- `step` input 1: manual advance. Synchronous to `clk` and already debounced.
- `dir` input 1: 1 = up/increasing; 0 = down. Used by the binary, Gray and bar modes.
- `tick` output 1: one-cycle pulse, once every DIV cycles.
- `pmod_16led` output N_LED: LED drive, active-high, registered.

## Operation
- **Divider**
  - Counter `div_cnt` counts 0..DIV-1.
  - At DIV-1 it returns to 0, and the next cycle has `tick`=1.
  - It free-runs independent of `run`, `mode` and `step`.
- **Advance event `adv`**
  - Asserted when `run`=1 and a tick occurs.
  - Also asserted when `run`=0 and `step`=1 while `step_q`=0, where `step_q` is `step` registered.
  - When `run`=1, `step` is ignored.
- **Mode change**
  - `mode_q` registers `mode`.
  - If `mode` differs from `mode_q`, the pattern state loads the start value for the new mode.
  - If a mode change and `adv` occur in the same cycle, the mode change wins and the advance is dropped.
- **Pattern state**
  - W-bit counter `cnt`.
  - Scanner position `pos`, range 0..W-1.
  - Scanner direction `sdir`.
  - Bar level `lvl`, range 0..W.
- **Mode 00, binary**
  - Display `cnt`.
  - On `adv`, `cnt` increments when `dir`=1 and decrements when `dir`=0, wrapping modulo 2^W.
  - Start value: `cnt`=0.
- **Mode 01, Gray**
  - Same counter as mode 00, displayed as `cnt ^ (cnt >> 1)`.
  - Start value: `cnt`=0.
- **Mode 10, scanner**
  - Display one-hot `1 << pos`.
  - On `adv`, `pos` moves one step in `sdir`.
  - At `pos`=W-1, `sdir` flips to down. At `pos`=0, `sdir` flips to up.
  - The endpoint LED is held for exactly one step.
  - Ignores `dir`.
  - Start value: `pos`=0, `sdir`=up.
- **Mode 11, bar**
  - Display thermometer code: the low `lvl` bits are set.
  - On `adv` with `dir`=1: `lvl`+1, and W wraps to 0.
  - On `adv` with `dir`=0: `lvl`-1, and 0 wraps to W.
  - Start value: `lvl`=0.
- **Heartbeat** (HB_EN=1)
  - `hb` toggles on every tick regardless of `run`.
  - Drives `pmod_16led[N_LED-1]`.
- **Reset values** (while `rst_n`=0)
  - `div_cnt`, `cnt`, `pos`, `lvl`: 0.
  - `sdir`: up.
  - `mode_q`: 00.
  - `step_q`: 0.
  - `tick`: 0.
  - `hb`: 1.
  - `pmod_16led`: 0x8000 for the defaults. With HB_EN=0 it is all zeros.

## Timing
- State updates on the `clk` edge where `adv` or a mode change is true.
- `pmod_16led` reflects the new state one cycle later, as a registered decode.
- `tick` is high for exactly one cycle per DIV cycles. The first tick after reset release comes DIV cycles later.
- A `step` edge affects the LEDs 2 cycles after `step` rises: one cycle for edge detection and one for the output register.
- A mode change is visible on the LEDs 2 cycles after `mode` changes.
- Reset is asynchronous. Asserting `rst_n` mid-pattern clears all state and outputs immediately. Release is synchronous to `clk`; the top level provides the synchroniser.
- Holding `step` high produces one advance only.
- A `step` edge in the same cycle as a tick while `run`=0 produces one advance.

## Test plan
- **Reset and divider** (DIV=4, N_LED=16, HB_EN=1):
  - Hold reset, then release with mode=00, run=1, dir=1.
  - Output is 0x8000 during reset.
  - `tick` occurs every 4 cycles.
  - LEDs go 0x0001 with hb=0, then 0x8002, and so on.
  - After 32768 advances, the lower 15 bits wrap to 0.
- **Down count and Gray**
  - mode=00, dir=0 from reset: lower bits show 0x7FFF after the first advance.
  - Switch to mode=01 with dir=1: the state reloads to 0, then the lower bits show 1, 3, 2, 6.
- **Scanner bounce** (N_LED=5, HB_EN=0):
  - Lower bits sequence is 0x01, 0x02, 0x04, 0x08, 0x10, 0x08, ..., 0x01, 0x02.
  - `dir` toggling has no effect.
- **Bar wrap**
  - N_LED=5, HB_EN=0, mode=11.
  - dir=1 gives 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x00.
  - dir=0 from 0x00 gives 0x1F.
- **Manual step**
  - run=0: ticks cause no advance, but hb still toggles.
  - A 10-cycle `step` pulse gives exactly one advance, 2 cycles after the rise.
  - A `step` with run=1 is ignored.
- **Collisions and mid-reset**
  - A mode change in the same cycle as `adv` gives the start pattern with no advance.
  - Asserting `rst_n`=0 mid-sequence drives the outputs to 0x8000 asynchronously, before the next `clk` edge.
